uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Runs entirely in the `sys_clk` domain. Bit timing comes from an oversampling tick enable supplied by the shared baud generator; there is no second clock.
- Adds configurable data width, oversampling ratio, parity (none/even/odd) and 1 or 2 stop bits.
- Reports parity and framing errors per frame.
- Sits between the pad-side serial input and the RX FIFO / host register block.

Parameters:
- DATA_BITS, 8: data bits per frame. Legal 5..9.
- OVERSAMPLE, 16: `s_tick` pulses per bit period. Even, 8..32.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame. Legal 1 or 2.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-low reset.
- s_tick  in  1  oversample enable; one-`sys_clk`-cycle pulse, OVERSAMPLE per bit.
- rx_data_in  in  1  asynchronous serial input; idles high.
- rx_dout  out  DATA_BITS  last received data word, LSB = first bit on the line.
- rx_done_tick  out  1  one-cycle pulse: frame complete, `rx_dout`/error flags updated.
- parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY_MODE = 0.
- frame_err  out  1  a stop bit was sampled low on the last frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset and input synchronisation
- Reset is synchronous, active-low, checked on `sys_clk` rising edge, and takes priority over everything.
- Reset values: `rx_dout` = 0, `rx_done_tick` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, FSM = IDLE, all counters 0.
- `rx_data_in` passes through a 2-flop synchroniser (both flops reset to 1). All decisions below use the synchronised value `rxs`.
- Synchroniser latency: 2 cycles.

Counters
- `tick_cnt`: width clog2(OVERSAMPLE). Advances only on cycles where `s_tick` = 1.
- `bit_cnt`: width clog2(DATA_BITS+1).

FSM
- IDLE: when `rxs` = 0, go to START and clear `tick_cnt`. Ticks are ignored while in IDLE.
- START: on each `s_tick`, increment `tick_cnt`. When `tick_cnt` = OVERSAMPLE/2-1 and `s_tick` = 1 (mid start bit):
  - if `rxs` = 0, go to DATA and clear `tick_cnt` and `bit_cnt`;
  - if `rxs` = 1, this is a false start (glitch): return to IDLE with no outputs changed.
- DATA: on each `s_tick`, increment `tick_cnt`. At `tick_cnt` = OVERSAMPLE-1 (mid bit):
  - right-shift `rxs` into the MSB of `shreg`, clear `tick_cnt`, increment `bit_cnt`;
  - accumulate running parity as XOR of the bits;
  - after bit DATA_BITS, go to PARITY if PARITY_MODE ≠ 0, else to STOP.
- PARITY: sample at mid bit.
  - Even mode: error if (data XOR parity bit) = 1.
  - Odd mode: error if (data XOR parity bit) = 0.
  - Result is latched internally; then go to STOP.
- STOP: sample each of the STOP_BITS stop bits at mid bit; a low sample sets the internal frame-error flag. On the `s_tick` that samples the last stop bit:
  - on the next cycle, load `rx_dout` from `shreg`;
  - load `parity_err` and `frame_err` from the internal flags;
  - pulse `rx_done_tick` for exactly 1 cycle;
  - return to IDLE.

Output rules
- Done latency: `rx_done_tick` rises 1 `sys_clk` after the final stop-bit sampling tick.
- The FSM returns to IDLE at mid stop bit, so a back-to-back start edge half a bit later is accepted with no lost frame.
- Data is delivered even when an error flag is set.
- `rx_dout`, `parity_err` and `frame_err` hold until the next `rx_done_tick`.

Boundary conditions
- `rxs` held low throughout (break): the frame completes with `frame_err` = 1 and `rx_dout` = 0. The FSM then waits in IDLE for `rxs` = 1 before a new start is accepted; a low level is not treated as a new start edge.
- `s_tick` stuck low: the FSM freezes in its current state; `busy` stays high.
- Reset mid-frame: the partial frame is discarded, no `rx_done_tick` is issued, and outputs return to their reset values.

Test Plan:
1. 8N1 default, OVERSAMPLE = 16, `s_tick` every 4 cycles, send 0xA5 LSB-first → one `rx_done_tick`; `rx_dout` = 0xA5; `parity_err` = 0; `frame_err` = 0; `busy` low after done.
2. PARITY_MODE = 1 (even), send 0x03 with parity bit 0 → `parity_err` = 0. Send 0x03 with parity bit 1 → `parity_err` = 1 and `rx_dout` = 0x03. Repeat with PARITY_MODE = 2 (odd) → flags inverted.
3. STOP_BITS = 2, send 0x5A with the second stop bit driven low → `rx_dout` = 0x5A, `frame_err` = 1.
4. Low glitch of 3 ticks on an idle line → no `rx_done_tick`; `busy` pulses then returns to 0; `rx_dout` unchanged.
5. Back-to-back frames 0x11, 0x22, 0x33 with no idle gap → three `rx_done_tick` pulses with `rx_dout` = 0x11, 0x22, 0x33 in order; all error flags 0.
6. Assert `rst` = 0 during data bit 4 of 0xFF, release, then send 0x3C → no done pulse for the aborted frame; next done gives `rx_dout` = 0x3C. DATA_BITS = 7 variant: 0x7F → `rx_dout` = 0x7F.

Source files
------------

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param_if
//  Brief    : Bit-timing inputs and frame outputs of the parametrised UART RX.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_tick;
    logic                 rx_data_in;
    logic [DATA_BITS-1:0] rx_dout;
    logic                 rx_done_tick;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output s_tick,
        output rx_data_in,
        input  rx_dout,
        input  rx_done_tick,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  s_tick,
        input  rx_data_in,
        output rx_dout,
        output rx_done_tick,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Brief    : Oversampling UART receiver, configurable width/parity/stop bits.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic           sys_clk,
    input  logic           rst,
    uart_rx_param_if.slave rx
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);

    localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rxs;

    state_t               r_state;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par;
    logic                 r_perr_int;
    logic                 r_ferr_int;
    logic                 r_armed;

    logic [DATA_BITS-1:0] r_dout;
    logic                 r_done;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx.rx_data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // r_armed blocks a held-low line (break) from being taken as a new start:
    // the line must be seen high after a frame before the next start counts.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
            r_armed    <= 1'b0;
            r_dout     <= '0;
            r_done     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rxs) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!w_rxs && r_armed) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                        r_armed    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (rx.s_tick) begin
                        if (r_tick_cnt == c_tick_mid) begin
                            r_tick_cnt <= '0;
                            if (!w_rxs) begin
                                r_state    <= DATA;
                                r_bit_cnt  <= '0;
                                r_par      <= 1'b0;
                                r_perr_int <= 1'b0;
                                r_ferr_int <= 1'b0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx.s_tick) begin
                        if (r_tick_cnt == c_tick_last) begin
                            r_tick_cnt <= '0;
                            r_shreg    <= {w_rxs, r_shreg[DATA_BITS-1:1]};
                            r_par      <= r_par ^ w_rxs;
                            if (r_bit_cnt == c_bit_last) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (rx.s_tick) begin
                        if (r_tick_cnt == c_tick_last) begin
                            r_tick_cnt <= '0;
                            r_perr_int <= (PARITY_MODE == 2) ? ~(r_par ^ w_rxs)
                                                             :  (r_par ^ w_rxs);
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (rx.s_tick) begin
                        if (r_tick_cnt == c_tick_last) begin
                            r_tick_cnt <= '0;
                            if (!w_rxs) begin
                                r_ferr_int <= 1'b1;
                            end
                            if (r_bit_cnt == c_stop_last) begin
                                r_bit_cnt <= '0;
                                r_dout    <= r_shreg;
                                r_perr    <= r_perr_int;
                                r_ferr    <= r_ferr_int | ~w_rxs;
                                r_done    <= 1'b1;
                                r_busy    <= 1'b0;
                                r_armed   <= w_rxs;
                                r_state   <= IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_dout      = r_dout;
    assign rx.rx_done_tick = r_done;
    assign rx.parity_err   = r_perr;
    assign rx.frame_err    = r_ferr;
    assign rx.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_param
//  Brief    : Scoreboard bench for uart_rx_param across five configurations.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int N_DUT = 5;
    localparam int OVS   = 16;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    logic s_tick  = 1'b0;
    logic tick_en = 1'b1;
    int   tdiv    = 0;

    logic       rx_line [N_DUT];
    logic [8:0] dout_v  [N_DUT];
    logic       done_v  [N_DUT];
    logic       perr_v  [N_DUT];
    logic       ferr_v  [N_DUT];
    logic       busy_v  [N_DUT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q [$];
    exp_t m_e;

    always #5 sys_clk = ~sys_clk;

    // dut0 8N1, dut1 even parity, dut2 odd parity, dut3 two stop bits, dut4 7N1
    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(8)) if2 ();
    uart_rx_param_if #(.DATA_BITS(8)) if3 ();
    uart_rx_param_if #(.DATA_BITS(7)) if4 ();

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY_MODE(0), .STOP_BITS(1))
        dut0 (.sys_clk(sys_clk), .rst(rst), .rx(if0.slave));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY_MODE(1), .STOP_BITS(1))
        dut1 (.sys_clk(sys_clk), .rst(rst), .rx(if1.slave));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY_MODE(2), .STOP_BITS(1))
        dut2 (.sys_clk(sys_clk), .rst(rst), .rx(if2.slave));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY_MODE(0), .STOP_BITS(2))
        dut3 (.sys_clk(sys_clk), .rst(rst), .rx(if3.slave));
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OVS), .PARITY_MODE(0), .STOP_BITS(1))
        dut4 (.sys_clk(sys_clk), .rst(rst), .rx(if4.slave));

    assign if0.s_tick = s_tick;  assign if0.rx_data_in = rx_line[0];
    assign if1.s_tick = s_tick;  assign if1.rx_data_in = rx_line[1];
    assign if2.s_tick = s_tick;  assign if2.rx_data_in = rx_line[2];
    assign if3.s_tick = s_tick;  assign if3.rx_data_in = rx_line[3];
    assign if4.s_tick = s_tick;  assign if4.rx_data_in = rx_line[4];

    assign dout_v[0] = {1'b0, if0.rx_dout};  assign done_v[0] = if0.rx_done_tick;
    assign dout_v[1] = {1'b0, if1.rx_dout};  assign done_v[1] = if1.rx_done_tick;
    assign dout_v[2] = {1'b0, if2.rx_dout};  assign done_v[2] = if2.rx_done_tick;
    assign dout_v[3] = {1'b0, if3.rx_dout};  assign done_v[3] = if3.rx_done_tick;
    assign dout_v[4] = {2'b0, if4.rx_dout};  assign done_v[4] = if4.rx_done_tick;
    assign perr_v[0] = if0.parity_err;  assign ferr_v[0] = if0.frame_err;  assign busy_v[0] = if0.busy;
    assign perr_v[1] = if1.parity_err;  assign ferr_v[1] = if1.frame_err;  assign busy_v[1] = if1.busy;
    assign perr_v[2] = if2.parity_err;  assign ferr_v[2] = if2.frame_err;  assign busy_v[2] = if2.busy;
    assign perr_v[3] = if3.parity_err;  assign ferr_v[3] = if3.frame_err;  assign busy_v[3] = if3.busy;
    assign perr_v[4] = if4.parity_err;  assign ferr_v[4] = if4.frame_err;  assign busy_v[4] = if4.busy;

    // one-cycle tick every fourth clock, gated by tick_en
    initial begin
        forever begin
            @(negedge sys_clk);
            tdiv   = (tdiv + 1) % 4;
            s_tick = tick_en && (tdiv == 0);
        end
    end

    // scoreboard monitor: every done pulse consumes one expected frame
    always @(negedge sys_clk) begin
        for (int d = 0; d < N_DUT; d++) begin
            if (done_v[d]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done dut%0d actual data=%h perr=%b ferr=%b required no frame",
                             d, dout_v[d], perr_v[d], ferr_v[d]);
                end else begin
                    m_e = exp_q.pop_front();
                    if (m_e.dut != d || m_e.data != dout_v[d] ||
                        m_e.perr != perr_v[d] || m_e.ferr != ferr_v[d]) begin
                        errors++;
                        $display("FAIL frame actual dut%0d data=%h perr=%b ferr=%b required dut%0d data=%h perr=%b ferr=%b",
                                 d, dout_v[d], perr_v[d], ferr_v[d],
                                 m_e.dut, m_e.data, m_e.perr, m_e.ferr);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input int d, input logic [8:0] data,
                                     input logic perr, input logic ferr);
        exp_t e;
        e.dut  = d;
        e.data = data;
        e.perr = perr;
        e.ferr = ferr;
        exp_q.push_back(e);
    endfunction

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge sys_clk);
            if (s_tick) k++;
        end
    endtask

    task automatic drive_bit(input int d, input logic b);
        @(negedge sys_clk);
        rx_line[d] = b;
        wait_ticks(OVS);
    endtask

    task automatic send(input int d, input logic [8:0] data, input int nd,
                        input bit use_par, input logic pbit,
                        input logic stop1, input logic stop2, input int nstop);
        drive_bit(d, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(d, data[i]);
        if (use_par) drive_bit(d, pbit);
        drive_bit(d, stop1);
        if (nstop == 2) drive_bit(d, stop2);
        @(negedge sys_clk);
        rx_line[d] = 1'b1;
    endtask

    task automatic check_reset_state(input int d);
        check($sformatf("reset_dout_dut%0d", d), int'(dout_v[d]), 0);
        check($sformatf("reset_flags_dut%0d", d),
              int'({done_v[d], perr_v[d], ferr_v[d], busy_v[d]}), 0);
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) rx_line[d] = 1'b1;
        repeat (5) @(negedge sys_clk);
        for (int d = 0; d < N_DUT; d++) check_reset_state(d);
        rst = 1'b1;
        repeat (10) @(negedge sys_clk);

        // 8N1 basic frame
        push_exp(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        wait_ticks(4);
        @(negedge sys_clk);
        check("t1_busy_after_done", int'(busy_v[0]), 0);

        // short low glitch is rejected
        @(negedge sys_clk);
        rx_line[0] = 1'b0;
        wait_ticks(3);
        @(negedge sys_clk);
        rx_line[0] = 1'b1;
        check("glitch_busy_during", int'(busy_v[0]), 1);
        wait_ticks(12);
        @(negedge sys_clk);
        check("glitch_busy_after", int'(busy_v[0]), 0);
        check("glitch_dout_held", int'(dout_v[0]), 'hA5);

        // even parity then odd parity, parity bit 0 and 1
        push_exp(1, 9'h003, 1'b0, 1'b0);
        send(1, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        push_exp(1, 9'h003, 1'b1, 1'b0);
        send(1, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        push_exp(1, 9'h007, 1'b0, 1'b0);
        send(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        push_exp(2, 9'h003, 1'b1, 1'b0);
        send(2, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        push_exp(2, 9'h003, 1'b0, 1'b0);
        send(2, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);

        // two stop bits: clean, second low, first low
        push_exp(3, 9'h05A, 1'b0, 1'b0);
        send(3, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        push_exp(3, 9'h05A, 1'b0, 1'b1);
        send(3, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        wait_ticks(OVS);
        push_exp(3, 9'h0C3, 1'b0, 1'b1);
        send(3, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        wait_ticks(OVS);

        // back-to-back frames without idle gap
        push_exp(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        push_exp(0, 9'h022, 1'b0, 1'b0);
        send(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        push_exp(0, 9'h033, 1'b0, 1'b0);
        send(0, 9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        wait_ticks(OVS);

        // break: line held low well past one frame
        push_exp(0, 9'h000, 1'b0, 1'b1);
        @(negedge sys_clk);
        rx_line[0] = 1'b0;
        wait_ticks(OVS * 12);
        @(negedge sys_clk);
        check("break_no_restart_busy", int'(busy_v[0]), 0);
        rx_line[0] = 1'b1;
        wait_ticks(OVS * 2);
        push_exp(0, 9'h081, 1'b0, 1'b0);
        send(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        wait_ticks(OVS);

        // 0xFF aborted at data bit 4: stall ticks, then reset
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        @(negedge sys_clk);
        rx_line[0] = 1'b1;
        wait_ticks(OVS / 2);
        @(negedge sys_clk);
        tick_en = 1'b0;
        repeat (40) @(negedge sys_clk);
        check("tick_stall_busy", int'(busy_v[0]), 1);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_reset_state(0);
        rst     = 1'b1;
        tick_en = 1'b1;
        wait_ticks(OVS * 2);
        push_exp(0, 9'h03C, 1'b0, 1'b0);
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);

        // 7-bit data width
        push_exp(4, 9'h07F, 1'b0, 1'b0);
        send(4, 9'h07F, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        push_exp(4, 9'h015, 1'b0, 1'b0);
        send(4, 9'h015, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1);

        wait_ticks(OVS * 2);
        @(negedge sys_clk);
        check("frames_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
